stream_buffer_allocator: RTL

// Shares a fixed pool of card-memory slots between NUM_CLIENTS stream buffer writers.
// - Each writer requests one slot per allocation; a round-robin arbiter grants the lowest-indexed free slot.
// - Consumers on the far side of the stream buffer links return slots through the free port.
// - A drain request stops new grants until every slot is back, then acknowledges. Used before a pool reset or reconfiguration.

---
 rtl/stream_buffer_allocator_if.sv | 27 ++
 rtl/stream_buffer_allocator.sv | 138 +++++++++++++
 2 files changed

// File: rtl/stream_buffer_allocator_if.sv
// Handshake bundle between stream buffer writers/consumers and the slot allocator.
interface stream_buffer_allocator_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int NUM_SLOTS   = 16,
    parameter int VADDR_W     = 64
);
    logic [NUM_CLIENTS-1:0]         req_valid;
    logic [NUM_CLIENTS-1:0]         req_ready;
    logic [VADDR_W-1:0]             grant_vaddr;
    logic                           free_valid;
    logic                           free_ready;
    logic [VADDR_W-1:0]             free_vaddr;
    logic                           drain_req;
    logic                           drain_done;
    logic [$clog2(NUM_SLOTS):0]     free_count;
    logic                           error;

    modport master (
        output req_valid, free_valid, free_vaddr, drain_req,
        input  req_ready, grant_vaddr, free_ready, drain_done, free_count, error
    );

    modport slave (
        input  req_valid, free_valid, free_vaddr, drain_req,
        output req_ready, grant_vaddr, free_ready, drain_done, free_count, error
    );
endinterface

// File: rtl/stream_buffer_allocator.sv
// Round-robin allocator handing out fixed-size card-memory slots to stream buffer
// writers, taking them back through a free port, with a drain handshake.
module stream_buffer_allocator #(
    parameter int NUM_CLIENTS = 4,
    parameter int NUM_SLOTS   = 16,
    parameter int SLOT_BYTES  = 4096,
    parameter int VADDR_W     = 64,
    parameter logic [VADDR_W-1:0] BASE_VADDR = '0
) (
    input  logic clk,
    input  logic rst_n,
    stream_buffer_allocator_if.slave bus
);
    localparam int SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CLI_W   = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CNT_W   = $clog2(NUM_SLOTS) + 1;
    localparam int SB_LOG2 = $clog2(SLOT_BYTES);

    typedef logic [VADDR_W-1:0] vaddress_t;
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE, ST_WAIT} state_t;

    logic [NUM_SLOTS-1:0]   bitmap;
    logic [NUM_SLOTS-1:0]   next_bitmap;
    logic [CNT_W-1:0]       free_cnt;
    logic [CLI_W-1:0]       rr_ptr;
    state_t                 state;
    logic                   active;
    logic                   drain_done_r;
    logic                   error_r;

    logic [CLI_W-1:0]       sel;
    logic                   sel_found;
    int                     cand;
    logic                   grant_ok;
    logic [SLOT_W-1:0]      low_idx;
    logic [NUM_CLIENTS-1:0] ready;

    vaddress_t              offset;
    vaddress_t              quot;
    logic [SLOT_W-1:0]      free_idx;
    logic                   addr_bad;
    logic                   free_fire;
    logic                   free_ok;
    logic                   free_err;

    function automatic logic [SLOT_W-1:0] first_set(input logic [NUM_SLOTS-1:0] map);
        first_set = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (map[i]) first_set = SLOT_W'(i);
    endfunction

    // Arbitration and slot selection, all from registered state.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_CLIENTS;
            if (!sel_found && bus.req_valid[CLI_W'(cand)]) begin
                sel_found = 1'b1;
                sel       = CLI_W'(cand);
            end
        end
        grant_ok = active && (state == ST_RUN) && (free_cnt != '0) && sel_found;
        for (int i = 0; i < NUM_CLIENTS; i++)
            ready[i] = grant_ok && (sel == CLI_W'(i));
        low_idx = first_set(bitmap);
    end

    // Free-path decode; the index is only trusted once range and alignment pass.
    always_comb begin
        offset    = bus.free_vaddr - BASE_VADDR;
        quot      = offset >> SB_LOG2;
        free_idx  = quot[SLOT_W-1:0];
        addr_bad  = (bus.free_vaddr < BASE_VADDR)
                  || ((offset & vaddress_t'(SLOT_BYTES - 1)) != '0)
                  || (quot >= vaddress_t'(NUM_SLOTS));
        free_fire = bus.free_valid && active;
        free_ok   = free_fire && !addr_bad && !bitmap[free_idx];
        free_err  = free_fire && (addr_bad || bitmap[free_idx]);

        next_bitmap = bitmap;
        if (grant_ok) next_bitmap[low_idx]  = 1'b0;
        if (free_ok)  next_bitmap[free_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap   <= '1;
            free_cnt <= CNT_W'(NUM_SLOTS);
            rr_ptr   <= '0;
            active   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            active <= 1'b1;
            bitmap <= next_bitmap;
            if (free_err) error_r <= 1'b1;
            case ({grant_ok, free_ok})
                2'b10:   free_cnt <= free_cnt - CNT_W'(1);
                2'b01:   free_cnt <= free_cnt + CNT_W'(1);
                default: free_cnt <= free_cnt;
            endcase
            if (grant_ok)
                rr_ptr <= (sel == CLI_W'(NUM_CLIENTS - 1)) ? '0 : sel + CLI_W'(1);
        end
    end

    // Drain sequencing: block grants until the whole pool has come back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            drain_done_r <= 1'b0;
        end else begin
            drain_done_r <= 1'b0;
            case (state)
                ST_RUN:   if (bus.drain_req) state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (!bus.drain_req) begin
                        state <= ST_RUN;
                    end else if (free_cnt == CNT_W'(NUM_SLOTS)) begin
                        state        <= ST_DONE;
                        drain_done_r <= 1'b1;
                    end
                end
                ST_DONE:  state <= ST_WAIT;
                ST_WAIT:  if (!bus.drain_req) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    assign bus.req_ready   = ready;
    assign bus.grant_vaddr = BASE_VADDR + (vaddress_t'(low_idx) << SB_LOG2);
    assign bus.free_ready  = active;
    assign bus.drain_done  = drain_done_r;
    assign bus.free_count  = free_cnt;
    assign bus.error       = error_r;
endmodule
